// File: rtl/cmp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
// State encoding plus the index-width calculation.
package cmp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_COMP = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Width of the slice index, never below one bit.
   function automatic int idx_width(input int w);
      int c;
      c = clog2(w / 2);
      return (c < 1) ? 1 : c;
   endfunction

endpackage

// File: rtl/cmp2_slice.sv
// Combinational 2-bit unsigned compare.
// lt2 reuses the gt2 sum-of-products with the operands swapped.
module cmp2_slice (
   input  logic [1:0] a2,
   input  logic [1:0] b2,
   output logic       gt2,
   output logic       lt2
);

   assign gt2 = (a2[1] & ~b2[1])
              | (a2[1] & a2[0] & ~b2[0])
              | (a2[0] & ~b2[1] & ~b2[0]);

   assign lt2 = (b2[1] & ~a2[1])
              | (b2[1] & b2[0] & ~a2[0])
              | (b2[0] & ~a2[1] & ~a2[0]);

endmodule

// File: rtl/seq_mag_compare.sv
// Sequential W-bit magnitude comparator, MSB-first, two bits per clock.
// Exits at the first differing slice and pulses done_tick for one cycle.
module seq_mag_compare #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         ready,
   output logic         done_tick,
   output logic         gt,
   output logic         eq,
   output logic         lt
);

   import cmp_pkg::*;

   localparam int IW = idx_width(W);
   localparam logic [IW-1:0] IDX_TOP = IW'(W / 2 - 1);

   state_e         state_q, state_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic           gt_q, gt_d;
   logic           eq_q, eq_d;
   logic           lt_q, lt_d;

   logic [IW:0]    lsb;
   logic [1:0]     a_sl;
   logic [1:0]     b_sl;
   logic           sl_gt;
   logic           sl_lt;

   // Slice selected by idx feeds the single compare instance.
   assign lsb  = {idx_q, 1'b0};
   assign a_sl = a_q[lsb +: 2];
   assign b_sl = b_q[lsb +: 2];

   cmp2_slice u_slice (
      .a2  (a_sl),
      .b2  (b_sl),
      .gt2 (sl_gt),
      .lt2 (sl_lt)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      gt_d    = gt_q;
      eq_d    = eq_q;
      lt_d    = lt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               gt_d    = 1'b0;
               eq_d    = 1'b0;
               lt_d    = 1'b0;
               idx_d   = IDX_TOP;
               state_d = ST_COMP;
            end
         end
         ST_COMP: begin
            if (sl_gt) begin
               gt_d    = 1'b1;
               state_d = ST_DONE;
            end else if (sl_lt) begin
               lt_d    = 1'b1;
               state_d = ST_DONE;
            end else if (idx_q == '0) begin
               eq_d    = 1'b1;
               state_d = ST_DONE;
            end else begin
               idx_d   = idx_q - 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= IDX_TOP;
         a_q     <= '0;
         b_q     <= '0;
         gt_q    <= 1'b0;
         eq_q    <= 1'b0;
         lt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         gt_q    <= gt_d;
         eq_q    <= eq_d;
         lt_q    <= lt_d;
      end
   end

   assign ready     = (state_q == ST_IDLE);
   assign done_tick = (state_q == ST_DONE);
   assign gt        = gt_q;
   assign eq        = eq_q;
   assign lt        = lt_q;

endmodule
